// File: rtl/dac_config_scheduler.sv
// dac_config_scheduler: per-DAC settings are written into shadow registers and
// applied atomically at sample boundaries. An optional channel scan steps an
// enabled DAC's channel through [scan_lo, scan_hi] every scan_dwell samples.
module dac_config_scheduler #(
  parameter int NUM_DAC = 8,
  parameter int MS_WAIT = 99
) (
  input  logic                   dataclk,
  input  logic                   reset_n,
  input  logic [31:0]            main_state,
  input  logic [5:0]             channel,
  input  logic                   cfg_wr_en,
  input  logic [2:0]             cfg_wr_dac,
  input  logic [1:0]             cfg_wr_field,
  input  logic [15:0]            cfg_wr_data,
  input  logic                   commit_req,
  output logic                   commit_pending,
  output logic                   commit_ack,
  input  logic [NUM_DAC-1:0]     scan_en,
  input  logic [4:0]             scan_lo,
  input  logic [4:0]             scan_hi,
  input  logic [15:0]            scan_dwell,
  output logic                   sample_tick,
  output logic [NUM_DAC-1:0]     dac_en,
  output logic [4*NUM_DAC-1:0]   dac_stream,
  output logic [5*NUM_DAC-1:0]   dac_channel,
  output logic [16*NUM_DAC-1:0]  dac_thrsh,
  output logic [NUM_DAC-1:0]     dac_thrsh_pol
);

  // Shadow (host-written) settings
  logic [NUM_DAC-1:0]    sh_en_q,     sh_en_d;
  logic [4*NUM_DAC-1:0]  sh_stream_q, sh_stream_d;
  logic [5*NUM_DAC-1:0]  sh_ch_q,     sh_ch_d;
  logic [16*NUM_DAC-1:0] sh_thrsh_q,  sh_thrsh_d;
  logic [NUM_DAC-1:0]    sh_pol_q,    sh_pol_d;

  // Active (output) settings
  logic [NUM_DAC-1:0]    act_en_q,     act_en_d;
  logic [4*NUM_DAC-1:0]  act_stream_q, act_stream_d;
  logic [5*NUM_DAC-1:0]  act_ch_q,     act_ch_d;
  logic [16*NUM_DAC-1:0] act_thrsh_q,  act_thrsh_d;
  logic [NUM_DAC-1:0]    act_pol_q,    act_pol_d;

  // Control state
  logic        bnd_q, tick_q, tick_d;
  logic        pending_q, pending_d;
  logic        ack_q, ack_d;
  logic [15:0] cnt_q, cnt_d;

  logic bnd;
  logic apply;
  logic step;

  assign bnd   = (main_state == 32'(MS_WAIT)) && (channel == '0);
  assign tick_d = bnd && !bnd_q;
  assign apply = tick_q && pending_q;
  // Counter compares with >= so a dwell shortened below the current count still wraps promptly
  assign step  = tick_q && !apply && (scan_dwell != '0) && (cnt_q >= scan_dwell - 16'd1);

  // Shadow register write decode; out-of-range DAC indices match no loop entry
  always_comb begin
    sh_en_d     = sh_en_q;
    sh_stream_d = sh_stream_q;
    sh_ch_d     = sh_ch_q;
    sh_thrsh_d  = sh_thrsh_q;
    sh_pol_d    = sh_pol_q;
    if (cfg_wr_en) begin
      for (int unsigned d = 0; d < NUM_DAC; d++) begin
        if (32'(cfg_wr_dac) == d) begin
          case (cfg_wr_field)
            2'd0: begin
              sh_en_d[d]          = cfg_wr_data[15];
              sh_stream_d[4*d +: 4] = cfg_wr_data[8:5];
              sh_ch_d[5*d +: 5]     = cfg_wr_data[4:0];
            end
            2'd1:    sh_thrsh_d[16*d +: 16] = cfg_wr_data;
            2'd2:    sh_pol_d[d] = cfg_wr_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Commit handshake and dwell counter; a request in an apply cycle re-arms for the next tick
  always_comb begin
    pending_d = commit_req || (pending_q && !apply);
    ack_d     = apply;
    cnt_d     = cnt_q;
    if (apply) begin
      cnt_d = '0;
    end else if (tick_q && (scan_dwell != '0)) begin
      cnt_d = step ? '0 : cnt_q + 16'd1;
    end
  end

  // Active settings: commit copies shadows (taking priority over a scan step)
  always_comb begin
    act_en_d     = act_en_q;
    act_stream_d = act_stream_q;
    act_ch_d     = act_ch_q;
    act_thrsh_d  = act_thrsh_q;
    act_pol_d    = act_pol_q;
    if (apply) begin
      act_en_d     = sh_en_q;
      act_stream_d = sh_stream_q;
      act_ch_d     = sh_ch_q;
      act_thrsh_d  = sh_thrsh_q;
      act_pol_d    = sh_pol_q;
    end else if (step) begin
      for (int unsigned d = 0; d < NUM_DAC; d++) begin
        if (scan_en[d] && act_en_q[d]) begin
          if ((scan_lo > scan_hi) || (act_ch_q[5*d +: 5] >= scan_hi) ||
              (act_ch_q[5*d +: 5] < scan_lo)) begin
            act_ch_d[5*d +: 5] = scan_lo;
          end else begin
            act_ch_d[5*d +: 5] = act_ch_q[5*d +: 5] + 5'd1;
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge dataclk) begin
    if (!reset_n) begin
      sh_en_q      <= '0;
      sh_stream_q  <= '0;
      sh_ch_q      <= '0;
      sh_thrsh_q   <= '0;
      sh_pol_q     <= '0;
      act_en_q     <= '0;
      act_stream_q <= '0;
      act_ch_q     <= '0;
      act_thrsh_q  <= '0;
      act_pol_q    <= '0;
      bnd_q        <= 1'b0;
      tick_q       <= 1'b0;
      pending_q    <= 1'b0;
      ack_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sh_en_q      <= sh_en_d;
      sh_stream_q  <= sh_stream_d;
      sh_ch_q      <= sh_ch_d;
      sh_thrsh_q   <= sh_thrsh_d;
      sh_pol_q     <= sh_pol_d;
      act_en_q     <= act_en_d;
      act_stream_q <= act_stream_d;
      act_ch_q     <= act_ch_d;
      act_thrsh_q  <= act_thrsh_d;
      act_pol_q    <= act_pol_d;
      bnd_q        <= bnd;
      tick_q       <= tick_d;
      pending_q    <= pending_d;
      ack_q        <= ack_d;
      cnt_q        <= cnt_d;
    end
  end

  assign commit_pending = pending_q;
  assign commit_ack     = ack_q;
  assign sample_tick    = tick_q;
  assign dac_en         = act_en_q;
  assign dac_stream     = act_stream_q;
  assign dac_channel    = act_ch_q;
  assign dac_thrsh      = act_thrsh_q;
  assign dac_thrsh_pol  = act_pol_q;

endmodule

// File: tb/tb_dac_config_scheduler.sv
// Directed bench for dac_config_scheduler: sample sweeps, commits, scan stepping, reset.
module tb_dac_config_scheduler;

  localparam int NUM_DAC = 8;
  localparam int MS_WAIT = 99;

  logic         dataclk = 1'b0;
  logic         reset_n;
  logic [31:0]  main_state;
  logic [5:0]   channel;
  logic         cfg_wr_en;
  logic [2:0]   cfg_wr_dac;
  logic [1:0]   cfg_wr_field;
  logic [15:0]  cfg_wr_data;
  logic         commit_req;
  logic         commit_pending;
  logic         commit_ack;
  logic [7:0]   scan_en;
  logic [4:0]   scan_lo;
  logic [4:0]   scan_hi;
  logic [15:0]  scan_dwell;
  logic         sample_tick;
  logic [7:0]   dac_en;
  logic [31:0]  dac_stream;
  logic [39:0]  dac_channel;
  logic [127:0] dac_thrsh;
  logic [7:0]   dac_thrsh_pol;

  int errors = 0;
  int checks = 0;
  int ticks;
  int acks;

  always #5 dataclk = ~dataclk;

  dac_config_scheduler #(.NUM_DAC(NUM_DAC), .MS_WAIT(MS_WAIT)) dut (
    .dataclk(dataclk), .reset_n(reset_n), .main_state(main_state), .channel(channel),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_dac(cfg_wr_dac), .cfg_wr_field(cfg_wr_field),
    .cfg_wr_data(cfg_wr_data), .commit_req(commit_req), .commit_pending(commit_pending),
    .commit_ack(commit_ack), .scan_en(scan_en), .scan_lo(scan_lo), .scan_hi(scan_hi),
    .scan_dwell(scan_dwell), .sample_tick(sample_tick), .dac_en(dac_en),
    .dac_stream(dac_stream), .dac_channel(dac_channel), .dac_thrsh(dac_thrsh),
    .dac_thrsh_pol(dac_thrsh_pol)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] dac, input logic [1:0] fld, input logic [15:0] data);
    @(negedge dataclk);
    cfg_wr_en = 1'b1; cfg_wr_dac = dac; cfg_wr_field = fld; cfg_wr_data = data;
    @(negedge dataclk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic commit();
    @(negedge dataclk);
    commit_req = 1'b1;
    @(negedge dataclk);
    commit_req = 1'b0;
  endtask

  // One 35-slot SPI sweep; optional write / commit request injected at given slots
  task automatic sweep(input int wslot, input logic [2:0] wdac, input logic [1:0] wfld,
                       input logic [15:0] wdata, input int cslot);
    ticks = 0;
    acks  = 0;
    for (int s = 0; s < 35; s++) begin
      @(negedge dataclk);
      if (sample_tick) ticks++;
      if (commit_ack) acks++;
      main_state   = 32'(MS_WAIT);
      channel      = 6'(s);
      cfg_wr_en    = (s == wslot);
      cfg_wr_dac   = wdac;
      cfg_wr_field = wfld;
      cfg_wr_data  = wdata;
      commit_req   = (s == cslot);
    end
    @(negedge dataclk);
    if (commit_ack) acks++;
    main_state = '0;
    channel    = '0;
    cfg_wr_en  = 1'b0;
    commit_req = 1'b0;
  endtask

  task automatic plain_sweep();
    sweep(-1, 3'd0, 2'd0, 16'h0, -1);
  endtask

  function automatic logic [4:0] ch_of(input logic [39:0] v, input int d);
    return v[5*d +: 5];
  endfunction

  initial begin
    reset_n = 1'b0; main_state = '0; channel = '0;
    cfg_wr_en = 1'b0; cfg_wr_dac = '0; cfg_wr_field = '0; cfg_wr_data = '0;
    commit_req = 1'b0; scan_en = '0; scan_lo = '0; scan_hi = '0; scan_dwell = '0;
    repeat (3) @(negedge dataclk);
    check("rst_en", dac_en, 0);
    check("rst_ch", dac_channel, 0);
    check("rst_pend", commit_pending, 0);
    check("rst_tick", sample_tick, 0);
    reset_n = 1'b1;

    // Idle sweeps: one tick each, outputs remain zero
    for (int i = 0; i < 2; i++) begin
      plain_sweep();
      check("idle_ticks", ticks, 1);
      check("idle_acks", acks, 0);
      check("idle_en", dac_en, 0);
      check("idle_thrsh", dac_thrsh, 0);
    end

    // Shadow writes alone do not reach outputs
    wr(3'd2, 2'd0, 16'h80A7);
    wr(3'd2, 2'd1, 16'h1234);
    check("nocommit_en", dac_en, 0);
    plain_sweep();
    check("nocommit_en_sweep", dac_en, 0);
    check("nocommit_thrsh", dac_thrsh, 0);

    // Commit DAC2
    commit();
    check("pend_set", commit_pending, 1);
    plain_sweep();
    check("c1_acks", acks, 1);
    check("c1_en", dac_en, 8'h04);
    check("c1_stream", dac_stream[11:8], 4'd5);
    check("c1_ch", ch_of(dac_channel, 2), 5'd7);
    check("c1_thrsh", dac_thrsh[47:32], 16'h1234);
    check("c1_thrsh_other", dac_thrsh[31:0], 0);
    check("c1_pend_clr", commit_pending, 0);

    // Write and request in the copy cycle: both deferred to the next tick
    commit();
    sweep(1, 3'd0, 2'd0, 16'h8001, 1);
    check("cc_acks", acks, 1);
    check("cc_en0_not_applied", dac_en, 8'h04);
    check("cc_pend_relatched", commit_pending, 1);
    plain_sweep();
    check("cc2_acks", acks, 1);
    check("cc2_en", dac_en, 8'h05);
    check("cc2_ch0", ch_of(dac_channel, 0), 5'd1);

    // Scan DAC1 over [2,4] with dwell 3
    wr(3'd1, 2'd0, 16'h8003);
    scan_en = 8'h02; scan_lo = 5'd2; scan_hi = 5'd4; scan_dwell = 16'd3;
    commit();
    plain_sweep();
    check("scan_commit_ch1", ch_of(dac_channel, 1), 5'd3);
    begin
      logic [4:0] exp_seq [9] = '{5'd3, 5'd3, 5'd4, 5'd4, 5'd4, 5'd2, 5'd2, 5'd2, 5'd3};
      for (int i = 0; i < 9; i++) begin
        plain_sweep();
        check($sformatf("scan_seq%0d", i), ch_of(dac_channel, 1), exp_seq[i]);
      end
    end
    check("scan_ch0_untouched", ch_of(dac_channel, 0), 5'd1);

    // Dwell 0 freezes
    scan_dwell = 16'd0;
    for (int i = 0; i < 4; i++) plain_sweep();
    check("freeze_ch1", ch_of(dac_channel, 1), 5'd3);

    // Commit coincident with a step
    scan_dwell = 16'd3;
    plain_sweep();
    plain_sweep();
    check("pre_coinc_ch1", ch_of(dac_channel, 1), 5'd3);
    wr(3'd1, 2'd0, 16'h800A);
    commit();
    plain_sweep();
    check("coinc_ch1", ch_of(dac_channel, 1), 5'd10);
    plain_sweep();
    check("coinc_n1", ch_of(dac_channel, 1), 5'd10);
    plain_sweep();
    check("coinc_n2", ch_of(dac_channel, 1), 5'd10);
    plain_sweep();
    check("coinc_step", ch_of(dac_channel, 1), 5'd2);

    // Inverted range loads scan_lo
    scan_lo = 5'd6; scan_hi = 5'd4; scan_dwell = 16'd1;
    plain_sweep();
    check("inv_range", ch_of(dac_channel, 1), 5'd6);
    scan_dwell = 16'd0;

    // Polarity write, reserved field ignored; shadow channel untouched by scan
    wr(3'd3, 2'd2, 16'h0003);
    wr(3'd3, 2'd3, 16'hFFFF);
    commit();
    plain_sweep();
    check("pol", dac_thrsh_pol, 8'h08);
    check("pol_en", dac_en, 8'h07);
    check("pol_thrsh3", dac_thrsh[63:48], 16'h0000);
    check("shadow_ch1", ch_of(dac_channel, 1), 5'd10);

    // Reset while pending
    commit();
    check("rp_pend", commit_pending, 1);
    @(negedge dataclk);
    reset_n = 1'b0; main_state = 32'(MS_WAIT); channel = '0;
    repeat (2) @(negedge dataclk);
    reset_n = 1'b1; main_state = '0;
    @(negedge dataclk);
    check("rp_pend_clr", commit_pending, 0);
    check("rp_ack", commit_ack, 0);
    check("rp_en", dac_en, 0);
    check("rp_pol", dac_thrsh_pol, 0);
    plain_sweep();
    check("rp_sweep_acks", acks, 0);
    check("rp_sweep_ch", dac_channel, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
